// File: rtl/sync_debounce_filter.sv
// Synchronise, debounce and edge-detect a raw asynchronous 1-bit input.
// Optional saturating glitch counter enabled by SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter bit INIT_LEVEL    = 1'b0,
    parameter int GLITCH_CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic a_async,
    input  logic enable,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    // state | meaning
    // IDLE  | cnt == 0, sync_in agrees with level
    // CHECK | cnt != 0, candidate new level being timed
    typedef enum logic {IDLE, CHECK} state_t;

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   level_d, rise_d, fall_d;
    logic                   differ;
    state_t                 state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_async};
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign differ  = (sync_in != level);
    assign state   = (cnt == '0) ? IDLE : CHECK;
    assign busy    = (state == CHECK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= INIT_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            level <= level_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

    always_comb begin
        cnt_d   = cnt;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else begin
            case (state)
                IDLE, CHECK: begin
                    if (differ) begin
                        if (cnt == CNT_LAST) begin
                            level_d = sync_in;
                            cnt_d   = '0;
                            rise_d  = sync_in;
                            fall_d  = ~sync_in;
                        end else begin
                            cnt_d = cnt + CNT_W'(1);
                        end
                    end else begin
                        // Input fell back before the candidate matured: drop it.
                        cnt_d = '0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (enable && state == CHECK && !differ && glitch_cnt != '1) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sync_debounce_filter.sv
// Bench for sync_debounce_filter: directed literal checks plus random stimulus
// against a streak-counting reference model, compared after every clock edge.
module tb_sync_debounce_filter;

    localparam int S    = 2;
    localparam int N    = 4;
    localparam bit INIT = 1'b0;
    localparam int GW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a_async = 1'b0;
    logic enable = 1'b1;
    logic level, rise, fall, busy;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    sync_debounce_filter #(
        .SYNC_STAGES(S), .STABLE_CYCLES(N), .INIT_LEVEL(INIT), .GLITCH_CNT_W(GW)
    ) dut (
        .clk(clk), .rst(rst), .a_async(a_async), .enable(enable),
        .level(level), .rise(rise), .fall(fall), .busy(busy)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        , .glitch_cnt(glitch_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: level flips once N consecutive enabled edges have seen
    // a delayed input that disagrees with it.
    bit m_level, m_rise, m_fall;
    int streak;
    bit hist[$];
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    int m_glitch;
`endif

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_level = INIT; m_rise = 0; m_fall = 0; streak = 0;
                hist.delete();
                repeat (S) hist.push_back(INIT);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
                m_glitch = 0;
`endif
            end else begin
                bit seen;
                hist.push_front(a_async);
                seen = hist[S];
                void'(hist.pop_back());
                m_rise = 0; m_fall = 0;
                if (!enable) begin
                    streak = 0;
                end else if (seen != m_level) begin
                    streak++;
                    if (streak == N) begin
                        m_level = seen; m_rise = seen; m_fall = !seen; streak = 0;
                    end
                end else begin
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
                    if (streak != 0 && m_glitch < 255) m_glitch++;
`endif
                    streak = 0;
                end
            end
            #1;
            chk("level", level, m_level);
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("busy", busy, streak != 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
            chk("glitch_cnt", glitch_cnt, m_glitch);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rst_pulse();
        rst = 0; a_async = 0; enable = 1;
        tick(); tick();
        rst = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit pat[7];
        int hold;
        bit a;
        pat = '{1, 0, 1, 1, 1, 1, 1};

        tick(); tick();
        rst = 1;

        // Clean step
        rst_pulse();
        a_async = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("step_level", level, i >= 5);
            chk("step_rise", rise, i == 5);
            chk("step_busy", busy, i >= 2 && i <= 4);
            chk("step_fall", fall, 0);
        end
        tick();
        chk("step_rise_end", rise, 0);
        chk("step_level_hold", level, 1);

        // Short pulse rejected as glitch
        rst_pulse();
        for (int i = 0; i < 9; i++) begin
            a_async = (i < 3);
            tick();
            chk("glitch_level", level, 0);
            chk("glitch_rise", rise, 0);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_count", glitch_cnt, 1);
`endif

        // Bounce then settle high, then settle low
        rst_pulse();
        for (int i = 0; i < 7; i++) begin
            a_async = pat[i];
            tick();
            chk("bounce_level_low", level, 0);
        end
        tick();
        chk("bounce_level", level, 1);
        chk("bounce_rise", rise, 1);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        chk("bounce_glitch", glitch_cnt, 1);
`endif
        a_async = 0;
        for (int i = 8; i < 13; i++) begin
            tick();
            chk("bounce_hold_high", level, 1);
        end
        tick();
        chk("bounce_fall", fall, 1);
        chk("bounce_level_fell", level, 0);

        // Enable abort and restart
        rst_pulse();
        a_async = 1;
        repeat (5) tick();
        chk("abort_busy_before", busy, 1);
        enable = 0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_level", level, 0);
        tick();
        enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reenable_level_low", level, 0);
        end
        tick();
        chk("reenable_level", level, 1);
        chk("reenable_rise", rise, 1);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        chk("abort_glitch", glitch_cnt, 0);
`endif

        // Async reset mid-CHECK with level high
        a_async = 0;
        repeat (3) tick();
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_level", level, 1);
        #1 rst = 0;
        #1;
        chk("reset_level", level, 0);
        chk("reset_rise", rise, 0);
        chk("reset_fall", fall, 0);
        chk("reset_busy", busy, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        chk("reset_glitch", glitch_cnt, 0);
`endif
        tick();
        rst = 1;

        // Glitch counter saturation
        rst_pulse();
        for (int i = 0; i < 260; i++) begin
            a_async = 1; tick();
            a_async = 0; tick();
        end
        repeat (4) tick();
        chk("sat_level", level, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        chk("sat_glitch", glitch_cnt, 255);
`endif

        // Random bouncing input with occasional disable and reset
        hold = 0; a = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                a = ~a;
                hold = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 12) : $urandom_range(1, 4);
            end
            hold--;
            a_async = a;
            enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 499) == 0) rst_pulse();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
